kx_mem_responder: RTL and testbench
===================================

Name: kx_mem_responder

Overview:
- Memory-side responder for the KX9016 CPU bus. It answers the vma/rw strobes issued by the CPU control unit and holds a synchronous 16-bit word memory.
- Each access runs a fixed number of wait states and completes with a one-cycle ready pulse. Reads return data on rdata; writes update the memory array.
- Sits between the CPU address/data registers and the memory array. It also flags out-of-range accesses and writes that target the read-only low region.

Parameters:
- ADDR_BITS, 8, number of implemented address bits; the array holds 2**ADDR_BITS words of 16 bits.
- WAIT_STATES, 1, extra cycles inserted between capture and access; legal range 0..15.
- ROM_WORDS, 16, words at addresses 0..ROM_WORDS-1 are read-only.

Ports:
- clock  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- vma  input  1  valid memory address; requests an access when high.
- rw  input  1  access direction: 0 = read, 1 = write.
- addr  input  16  word address.
- wdata  input  16  write data.
- rdata  output  16  read data, registered.
- ready  output  1  one-cycle completion pulse.
- busy  output  1  high from capture until the DONE state is left.
- err  output  1  error qualifier, valid only while ready is high.

Behaviour:
- Reset (asynchronous): state = IDLE; rdata = 0; ready = 0; busy = 0; err = 0; wait counter = 0.
  - Array contents are not cleared by reset.
  - Reset during any state aborts the access. A pending write is discarded and the array is untouched.
- States: IDLE, WAIT, ACCESS, DONE.
- IDLE:
  - busy = 0.
  - If vma = 1 at a rising edge: capture addr, rw and wdata into internal registers.
  - Next state is WAIT if WAIT_STATES > 0, otherwise ACCESS. Load the counter with WAIT_STATES-1.
  - If vma = 0: stay in IDLE.
- WAIT:
  - busy = 1.
  - Counter decrements each cycle. Go to ACCESS when the counter is 0.
  - Input changes are ignored because the captured copies are used.
- ACCESS (busy = 1), one cycle:
  - Range fault: captured addr[15:ADDR_BITS] is non-zero.
  - ROM fault: rw = 1 and addr < ROM_WORDS.
  - Read with no range fault: rdata <= mem[addr[ADDR_BITS-1:0]] at the edge into DONE.
  - Read with a range fault: rdata <= 0.
  - Write with no fault: mem[addr] <= wdata at the edge into DONE; rdata is unchanged.
  - Any fault: err <= 1 at the edge into DONE and the array is untouched.
- DONE:
  - ready = 1, busy = 1, err as computed in ACCESS.
  - Next state is always IDLE. ready and err return to 0 at the edge into IDLE.
- Latency: with the capture edge as E0, ready is high during the cycle after edge E0+WAIT_STATES+1.
- rdata holds its value until the next successful or faulting read completes.
- Back-to-back accesses:
  - vma is only sampled in IDLE, so vma held high through DONE starts a new access at the first IDLE edge.
  - Minimum spacing between ready pulses is WAIT_STATES+3 cycles.
- Read-after-write to the same address returns the new data; the write is committed before IDLE.
- The counter width is 4 bits. WAIT_STATES = 0 bypasses the WAIT state entirely.

Test Plan:
- Reset, then write: WAIT_STATES=1. Assert reset, release, then write addr=0x0020 with wdata=0xBEEF.
  - ready is pulsed at E0+2 with err=0; busy is high for 3 cycles.
  - A following read of 0x0020 gives rdata=0xBEEF at its ready pulse.
- ROM protect: write 0x0005 with 0x1234 → ready with err=1. A later read of 0x0005 returns the prior contents, not 0x1234.
- Out of range: read 0x0100 (ADDR_BITS=8) → ready with err=1 and rdata=0x0000.
- Held vma: keep vma=1, rw=0 with addr 0x0020 and then 0x0021. Two ready pulses are exactly WAIT_STATES+3 = 4 cycles apart.
  - Addr changes during WAIT have no effect on the in-flight access.
- Reset mid-write: start a write of 0x00AA to 0x0030, then assert reset during WAIT.
  - Required: ready is never pulsed and all outputs go to 0.
  - A read of 0x0030 returns its old value.
- WAIT_STATES=0 build: a read completes with ready at E0+1, and the WAIT state is never entered.

Source files
------------

// File: rtl/kx_mem_responder_if.sv
// KX9016 CPU-to-memory bus bundle.
// The CPU drives the strobes and data; the responder drives completion and read data.
interface kx_mem_responder_if;
    logic        vma;
    logic        rw;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
    logic        ready;
    logic        busy;
    logic        err;

    modport master (
        output vma, rw, addr, wdata,
        input  rdata, ready, busy, err
    );

    modport slave (
        input  vma, rw, addr, wdata,
        output rdata, ready, busy, err
    );
endinterface

// File: rtl/kx_mem_responder.sv
// KX9016 memory responder: wait-stated access to a 16-bit word array,
// with out-of-range and read-only-region fault reporting.
module kx_mem_responder #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_STATES = 1,
    parameter int ROM_WORDS   = 16
) (
    input logic               clock,
    input logic               reset,
    kx_mem_responder_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACCESS,
        S_DONE
    } state_t;

    localparam int          DEPTH   = 1 << ADDR_BITS;
    localparam logic [3:0]  WS_LOAD = 4'(WAIT_STATES - 1);
    localparam logic [16:0] ROM_LIM = 17'(ROM_WORDS);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] addr_q, addr_d;
    logic        rw_q, rw_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] rdata_q, rdata_d;
    logic        ready_q, ready_d;
    logic        err_q, err_d;

    logic        range_fault;
    logic        rom_fault;
    logic        fault;
    logic        mem_we;

    logic [15:0] mem [DEPTH];

    always_comb begin
        range_fault = (addr_q >> ADDR_BITS) != 16'd0;
        rom_fault   = rw_q && ({1'b0, addr_q} < ROM_LIM);
        fault       = range_fault || rom_fault;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rw_d    = rw_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        mem_we  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.vma) begin
                    addr_d  = bus.addr;
                    rw_d    = bus.rw;
                    wdata_d = bus.wdata;
                    cnt_d   = WS_LOAD;
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACCESS;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_ACCESS;
                else               cnt_d   = cnt_q - 4'd1;
            end
            S_ACCESS: begin
                state_d = S_DONE;
                ready_d = 1'b1;
                err_d   = fault;
                // A faulting read still completes, returning zero.
                if (!rw_q) begin
                    rdata_d = range_fault ? 16'h0000
                                          : mem[addr_q[ADDR_BITS-1:0]];
                end
                mem_we = rw_q && !fault;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 16'h0000;
            rw_q    <= 1'b0;
            wdata_q <= 16'h0000;
            rdata_q <= 16'h0000;
            ready_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rw_q    <= rw_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            ready_q <= ready_d;
            err_q   <= err_d;
        end
    end

    // The array has no reset; mem_we is already gated by the reset state.
    always_ff @(posedge clock) begin
        if (mem_we) mem[addr_q[ADDR_BITS-1:0]] <= wdata_q;
    end

    assign bus.rdata = rdata_q;
    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.busy  = (state_q != S_IDLE);
endmodule

// File: tb/tb_kx_mem_responder.sv
// Bench for kx_mem_responder: a WAIT_STATES=1 and a WAIT_STATES=0 instance,
// checked every cycle against a cycle-count transaction model.
module tb_kx_mem_responder;
    logic clock = 1'b0;
    logic reset = 1'b0;
    bit   en    = 1'b0;
    int   tests = 0;
    int   fails = 0;
    longint cyc = 0;

    kx_mem_responder_if bus1 ();
    kx_mem_responder_if bus0 ();

    kx_mem_responder #(
        .ADDR_BITS  (8),
        .WAIT_STATES(1),
        .ROM_WORDS  (16)
    ) dut1 (
        .clock(clock),
        .reset(reset),
        .bus  (bus1)
    );

    kx_mem_responder #(
        .ADDR_BITS  (8),
        .WAIT_STATES(0),
        .ROM_WORDS  (16)
    ) dut0 (
        .clock(clock),
        .reset(reset),
        .bus  (bus0)
    );

    always #5 clock = ~clock;

    function automatic logic get_vma(int d);
        return (d == 1) ? bus1.vma : bus0.vma;
    endfunction
    function automatic logic get_rw(int d);
        return (d == 1) ? bus1.rw : bus0.rw;
    endfunction
    function automatic logic [15:0] get_addr(int d);
        return (d == 1) ? bus1.addr : bus0.addr;
    endfunction
    function automatic logic [15:0] get_wdata(int d);
        return (d == 1) ? bus1.wdata : bus0.wdata;
    endfunction
    function automatic logic get_ready(int d);
        return (d == 1) ? bus1.ready : bus0.ready;
    endfunction
    function automatic logic get_busy(int d);
        return (d == 1) ? bus1.busy : bus0.busy;
    endfunction
    function automatic logic get_err(int d);
        return (d == 1) ? bus1.err : bus0.err;
    endfunction
    function automatic logic [15:0] get_rdata(int d);
        return (d == 1) ? bus1.rdata : bus0.rdata;
    endfunction

    task automatic drive(input int d, input logic v, input logic rw,
                         input logic [15:0] a, input logic [15:0] wd);
        if (d == 1) begin
            bus1.vma = v; bus1.rw = rw; bus1.addr = a; bus1.wdata = wd;
        end else begin
            bus0.vma = v; bus0.rw = rw; bus0.addr = a; bus0.wdata = wd;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] a,
                       input logic [31:0] e);
        tests++;
        if (a !== e) begin
            fails++;
            $display("FAIL %s: got %0h want %0h", nm, a, e);
        end
    endtask

    task automatic chk_ne(input string nm, input logic [31:0] a,
                          input logic [31:0] e);
        tests++;
        if (a === e) begin
            fails++;
            $display("FAIL %s: got %0h want anything but %0h", nm, a, e);
        end
    endtask

    // Model: an access captured at edge n completes (ready high) after
    // edge n+WS+1 and frees the bus at edge n+WS+2.
    bit          act   [2];
    longint      done_e[2];
    logic        m_rw  [2];
    logic [15:0] m_a   [2];
    logic [15:0] m_wd  [2];
    logic [15:0] m_rd  [2];
    bit          m_rdk [2];
    bit          m_rdy [2];
    bit          m_bsy [2];
    bit          m_err [2];
    logic [15:0] mmem  [2][256];
    bit          mknown[2][256];

    task automatic model_step(input int d);
        bit rng, rom, f;
        if (act[d]) begin
            if (cyc == done_e[d]) begin
                rng = (m_a[d][15:8] != 8'h00);
                rom = m_rw[d] && (m_a[d] < 16'd16);
                f   = rng || rom;
                m_err[d] = f;
                m_rdy[d] = 1'b1;
                if (!m_rw[d]) begin
                    if (rng) begin
                        m_rd[d]  = 16'h0000;
                        m_rdk[d] = 1'b1;
                    end else begin
                        m_rd[d]  = mmem[d][m_a[d][7:0]];
                        m_rdk[d] = mknown[d][m_a[d][7:0]];
                    end
                end else if (!f) begin
                    mmem[d][m_a[d][7:0]]   = m_wd[d];
                    mknown[d][m_a[d][7:0]] = 1'b1;
                end
            end else if (cyc == done_e[d] + 1) begin
                act[d]   = 1'b0;
                m_rdy[d] = 1'b0;
                m_err[d] = 1'b0;
                m_bsy[d] = 1'b0;
            end
        end else if (get_vma(d)) begin
            act[d]    = 1'b1;
            done_e[d] = cyc + longint'(d) + 1;
            m_rw[d]   = get_rw(d);
            m_a[d]    = get_addr(d);
            m_wd[d]   = get_wdata(d);
            m_bsy[d]  = 1'b1;
        end
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int d = 0; d < 2; d++) begin
                act[d]   = 1'b0;
                m_rdy[d] = 1'b0;
                m_bsy[d] = 1'b0;
                m_err[d] = 1'b0;
                m_rd[d]  = 16'h0000;
                m_rdk[d] = 1'b1;
            end
        end else begin
            cyc++;
            for (int d = 0; d < 2; d++) model_step(d);
        end
    end

    always @(negedge clock) begin
        if (en) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("d%0d.ready", d), 32'(get_ready(d)), 32'(m_rdy[d]));
                chk($sformatf("d%0d.busy", d), 32'(get_busy(d)), 32'(m_bsy[d]));
                if (m_rdy[d])
                    chk($sformatf("d%0d.err", d), 32'(get_err(d)), 32'(m_err[d]));
                if (m_rdk[d])
                    chk($sformatf("d%0d.rdata", d), 32'(get_rdata(d)), 32'(m_rd[d]));
            end
        end
    end

    // One complete access; lat is ready cycle minus capture cycle.
    task automatic access(input int d, input logic rw, input logic [15:0] a,
                          input logic [15:0] wd, output int lat, output int bcnt,
                          output logic [15:0] rd, output logic e);
        longint c;
        bit got;
        got  = 1'b0;
        lat  = -1;
        bcnt = 0;
        rd   = 16'hxxxx;
        e    = 1'bx;
        @(negedge clock); #2;
        drive(d, 1'b1, rw, a, wd);
        @(posedge clock); #1;
        c = cyc;
        drive(d, 1'b0, 1'b0, 16'h0000, 16'h0000);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (get_busy(d)) bcnt++;
            if (get_ready(d) && !got) begin
                got = 1'b1;
                lat = int'(cyc - c);
                rd  = get_rdata(d);
                e   = get_err(d);
            end
            if (got && !get_busy(d)) break;
        end
        if (!got) chk("access_timeout", 32'd0, 32'd1);
    endtask

    int          lat, bc;
    logic [15:0] rd;
    logic        e;

    initial begin
        longint r1, r2;
        logic [15:0] rd1, rd2;
        int got;
        bit saw;

        for (int a = 0; a < 256; a++) begin
            mknown[0][a] = 1'b0;
            mknown[1][a] = 1'b0;
        end
        drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        drive(0, 1'b0, 1'b0, 16'h0000, 16'h0000);
        #1 reset = 1'b1;
        en = 1'b1;
        #2;
        for (int d = 0; d < 2; d++) begin
            chk("rst.ready", 32'(get_ready(d)), 32'd0);
            chk("rst.busy",  32'(get_busy(d)),  32'd0);
            chk("rst.err",   32'(get_err(d)),   32'd0);
            chk("rst.rdata", 32'(get_rdata(d)), 32'd0);
        end
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;

        access(1, 1'b1, 16'h0020, 16'hBEEF, lat, bc, rd, e);
        chk("w20.lat",  32'(lat), 32'd2);
        chk("w20.err",  32'(e),   32'd0);
        chk("w20.busy", 32'(bc),  32'd3);
        access(1, 1'b1, 16'h0021, 16'hCAFE, lat, bc, rd, e);
        chk("w21.err", 32'(e), 32'd0);
        access(1, 1'b0, 16'h0020, 16'h0000, lat, bc, rd, e);
        chk("r20.rdata", 32'(rd), 32'hBEEF);
        chk("r20.err",   32'(e),  32'd0);

        access(1, 1'b1, 16'h0005, 16'h1234, lat, bc, rd, e);
        chk("rom.err", 32'(e), 32'd1);
        access(1, 1'b0, 16'h0005, 16'h0000, lat, bc, rd, e);
        chk("rom_rd.err", 32'(e), 32'd0);
        chk_ne("rom_rd.rdata", 32'(rd), 32'h1234);

        access(1, 1'b0, 16'h0100, 16'h0000, lat, bc, rd, e);
        chk("oor.err",   32'(e),  32'd1);
        chk("oor.rdata", 32'(rd), 32'h0000);

        // Held vma: second address presented while the first is in WAIT.
        got = 0; r1 = 0; r2 = 0; rd1 = '0; rd2 = '0;
        @(negedge clock); #2;
        drive(1, 1'b1, 1'b0, 16'h0020, 16'h0000);
        @(posedge clock); #1;
        drive(1, 1'b1, 1'b0, 16'h0021, 16'h0000);
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (get_ready(1)) begin
                if (got == 0) begin
                    r1 = cyc; rd1 = get_rdata(1); got = 1;
                end else begin
                    r2 = cyc; rd2 = get_rdata(1); got = 2;
                    drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
                    break;
                end
            end
        end
        drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        chk("held.count",   32'(got),     32'd2);
        chk("held.spacing", 32'(r2 - r1), 32'd4);
        chk("held.rd1",     32'(rd1),     32'hBEEF);
        chk("held.rd2",     32'(rd2),     32'hCAFE);
        repeat (3) @(negedge clock);

        access(1, 1'b1, 16'h0030, 16'h5555, lat, bc, rd, e);
        chk("w30.err", 32'(e), 32'd0);
        @(negedge clock); #2;
        drive(1, 1'b1, 1'b1, 16'h0030, 16'h00AA);
        @(posedge clock); #1;
        drive(1, 1'b0, 1'b0, 16'h0000, 16'h0000);
        @(negedge clock); #2;
        reset = 1'b1;
        #1;
        chk("mid.ready", 32'(bus1.ready), 32'd0);
        chk("mid.busy",  32'(bus1.busy),  32'd0);
        chk("mid.err",   32'(bus1.err),   32'd0);
        chk("mid.rdata", 32'(bus1.rdata), 32'd0);
        saw = 1'b0;
        repeat (3) begin
            @(negedge clock);
            if (bus1.ready) saw = 1'b1;
        end
        #2 reset = 1'b0;
        chk("mid.no_ready", 32'(saw), 32'd0);
        access(1, 1'b0, 16'h0030, 16'h0000, lat, bc, rd, e);
        chk("r30.rdata", 32'(rd), 32'h5555);

        access(0, 1'b1, 16'h0040, 16'h0F0F, lat, bc, rd, e);
        chk("ws0.w.lat",  32'(lat), 32'd1);
        chk("ws0.w.busy", 32'(bc),  32'd2);
        access(0, 1'b0, 16'h0040, 16'h0000, lat, bc, rd, e);
        chk("ws0.r.lat",   32'(lat), 32'd1);
        chk("ws0.r.rdata", 32'(rd),  32'h0F0F);
        chk("ws0.r.err",   32'(e),   32'd0);
        access(0, 1'b0, 16'h0200, 16'h0000, lat, bc, rd, e);
        chk("ws0.oor.err", 32'(e), 32'd1);

        repeat (2) @(negedge clock);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
